// File: rtl/spi_pkg.sv
// Shared types and constants for the SPI responder register bank: FSM states,
// frame lengths, the address map and the bank reset values.
package spi_pkg;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_ADDR,
        ST_DATA,
        ST_DONE
    } spi_state_t;

    localparam int ADDR_BITS   = 8;
    localparam int FRAME_BITS  = 16;
    localparam int CNT_W       = 5;
    localparam int MAP_ENTRIES = 8;

    // Entry 0 is the least significant element of each packed table
    localparam logic [MAP_ENTRIES-1:0][6:0] REG_ADDR = {
        7'h2D, 7'h2C, 7'h2B, 7'h2A, 7'h1D, 7'h1C, 7'h1B, 7'h1A
    };

    localparam logic [MAP_ENTRIES-1:0][7:0] REG_RESET = {
        8'hE5, 8'h05, 8'hB5, 8'h8C, 8'h4E, 8'h3B, 8'hDC, 8'h41
    };

    // Returns {hit, index}; address bit 7 (the write flag) takes no part in the match
    function automatic logic [3:0] map_index(input logic [6:0] addr);
        logic [3:0] res;
        res = 4'b0000;
        for (int i = 0; i < MAP_ENTRIES; i++) begin
            if (addr == REG_ADDR[i]) begin
                res = {1'b1, 3'(i)};
            end
        end
        return res;
    endfunction

endpackage

// File: rtl/spi_sync.sv
// Multi-stage synchronizer for one asynchronous input, with single-cycle
// rise and fall pulses derived from the synchronized level.
module spi_sync #(
    parameter int   STAGES  = 2,
    parameter logic RST_VAL = 1'b0
) (
    input  logic i_clk,
    input  logic i_rst,
    input  logic i_async,
    output logic o_sync,
    output logic o_rise,
    output logic o_fall
);

    logic [STAGES-1:0] r_sync;
    logic              r_prev;

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_sync <= {STAGES{RST_VAL}};
            r_prev <= RST_VAL;
        end else begin
            r_sync <= {r_sync[STAGES-2:0], i_async};
            r_prev <= r_sync[STAGES-1];
        end
    end

    assign o_sync = r_sync[STAGES-1];
    assign o_rise = r_sync[STAGES-1] & ~r_prev;
    assign o_fall = ~r_sync[STAGES-1] & r_prev;

endmodule

// File: rtl/spi_responder_regs.sv
// SPI mode-0 responder with an 8-entry register bank (8-bit address, 8-bit data).
// Define SPI_RESPONDER_WRITE_EN to make the bank writable; otherwise it is constant.
module spi_responder_regs
    import spi_pkg::*;
#(
    parameter int SYNC_STAGES = 2,
    parameter int NUM_REGS    = 8
) (
    input  logic       CLK,
    input  logic       RST,
    input  logic       SCLK,
    input  logic       MOSI,
    input  logic       SS,
    output logic       MISO,
    output logic       FRAME_DONE,
    output logic [7:0] LAST_ADDR
);

    localparam int N_BANK = (NUM_REGS < MAP_ENTRIES) ? NUM_REGS : MAP_ENTRIES;

    logic w_sclk_sync_unused, w_sclk_rise, w_sclk_fall;
    logic w_ss_sync, w_ss_rise_unused, w_ss_fall;
    logic w_mosi_sync, w_mosi_rise_unused, w_mosi_fall_unused;

    spi_sync #(.STAGES(SYNC_STAGES), .RST_VAL(1'b0)) u_sclk_sync (
        .i_clk(CLK), .i_rst(RST), .i_async(SCLK),
        .o_sync(w_sclk_sync_unused), .o_rise(w_sclk_rise), .o_fall(w_sclk_fall)
    );

    spi_sync #(.STAGES(SYNC_STAGES), .RST_VAL(1'b1)) u_ss_sync (
        .i_clk(CLK), .i_rst(RST), .i_async(SS),
        .o_sync(w_ss_sync), .o_rise(w_ss_rise_unused), .o_fall(w_ss_fall)
    );

    spi_sync #(.STAGES(SYNC_STAGES), .RST_VAL(1'b0)) u_mosi_sync (
        .i_clk(CLK), .i_rst(RST), .i_async(MOSI),
        .o_sync(w_mosi_sync), .o_rise(w_mosi_rise_unused), .o_fall(w_mosi_fall_unused)
    );

    spi_state_t       r_state;
    logic [CNT_W-1:0] r_bit_cnt;
    logic [7:0]       r_addr;
    logic [7:0]       r_miso_sr;
    logic             r_load;
    logic             r_miso;
    logic             r_frame_done;
    logic [7:0]       r_last_addr;

    logic [3:0] w_map;
    logic [2:0] w_idx;
    logic       w_hit;
    logic [7:0] w_rd_data;

    assign w_map = map_index(r_addr[6:0]);
    assign w_idx = w_map[2:0];
    assign w_hit = w_map[3] && (int'(w_idx) < N_BANK);

`ifdef SPI_RESPONDER_WRITE_EN
    logic [7:0] r_bank [N_BANK];
    logic [7:0] r_data;

    always_ff @(posedge CLK) begin
        if (r_state == ST_DATA && w_sclk_rise) begin
            r_data <= {r_data[6:0], w_mosi_sync};
        end
    end

    // Commit happens in DONE; SS already high by then aborts the write
    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            for (int i = 0; i < N_BANK; i++) begin
                r_bank[i] <= REG_RESET[i];
            end
        end else if (r_state == ST_DONE && !w_ss_sync && r_addr[7] && w_hit) begin
            r_bank[w_idx] <= r_data;
        end
    end

    assign w_rd_data = w_hit ? r_bank[w_idx] : 8'h00;
`else
    assign w_rd_data = w_hit ? REG_RESET[w_idx] : 8'h00;
`endif

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            r_state      <= ST_IDLE;
            r_bit_cnt    <= '0;
            r_addr       <= '0;
            r_miso_sr    <= '0;
            r_load       <= 1'b0;
            r_miso       <= 1'b0;
            r_frame_done <= 1'b0;
            r_last_addr  <= '0;
        end else begin
            r_frame_done <= 1'b0;
            if (w_ss_sync) begin
                r_state   <= ST_IDLE;
                r_bit_cnt <= '0;
                r_miso    <= 1'b0;
                r_load    <= 1'b0;
            end else begin
                case (r_state)
                    ST_IDLE: begin
                        r_miso <= 1'b0;
                        if (w_ss_fall) begin
                            r_state   <= ST_ADDR;
                            r_bit_cnt <= '0;
                        end
                    end
                    ST_ADDR: begin
                        if (w_sclk_rise) begin
                            r_addr    <= {r_addr[6:0], w_mosi_sync};
                            r_bit_cnt <= r_bit_cnt + 1'b1;
                            if (r_bit_cnt == CNT_W'(ADDR_BITS - 1)) begin
                                r_state <= ST_DATA;
                                r_load  <= 1'b1;
                            end
                        end
                    end
                    ST_DATA: begin
                        // Write frames load zeros so MISO stays low throughout
                        if (r_load) begin
                            r_load    <= 1'b0;
                            r_miso_sr <= r_addr[7] ? 8'h00 : w_rd_data;
                        end else if (w_sclk_fall) begin
                            r_miso    <= r_miso_sr[7];
                            r_miso_sr <= {r_miso_sr[6:0], 1'b0};
                        end
                        if (w_sclk_rise) begin
                            r_bit_cnt <= r_bit_cnt + 1'b1;
                            if (r_bit_cnt == CNT_W'(FRAME_BITS - 1)) begin
                                r_state      <= ST_DONE;
                                r_frame_done <= 1'b1;
                                r_last_addr  <= r_addr;
                            end
                        end
                    end
                    ST_DONE: begin
                        r_state   <= ST_IDLE;
                        r_bit_cnt <= '0;
                        r_miso    <= 1'b0;
                    end
                    default: begin
                        r_state <= ST_IDLE;
                    end
                endcase
            end
        end
    end

    assign MISO       = r_miso;
    assign FRAME_DONE = r_frame_done;
    assign LAST_ADDR  = r_last_addr;

endmodule

// File: tb/tb_spi_responder_regs.sv
// Self-checking bench for spi_responder_regs: mode-0 frames driven by an initiator
// model, expected read bytes queued as a scoreboard, FRAME_DONE/LAST_ADDR monitored.
module tb_spi_responder_regs;
    import spi_pkg::*;

    localparam int SYNC = 2;
    localparam int HALF = 6;

    logic       CLK = 1'b0;
    logic       RST;
    logic       SCLK;
    logic       MOSI;
    logic       SS;
    logic       MISO;
    logic       FRAME_DONE;
    logic [7:0] LAST_ADDR;

    spi_responder_regs #(.SYNC_STAGES(SYNC), .NUM_REGS(8)) dut (
        .CLK(CLK), .RST(RST), .SCLK(SCLK), .MOSI(MOSI), .SS(SS),
        .MISO(MISO), .FRAME_DONE(FRAME_DONE), .LAST_ADDR(LAST_ADDR)
    );

    always #5 CLK = ~CLK;

    int checks = 0;
    int errors = 0;
    int fd_pulses = 0;
    int fd_run = 0;
    int fd_maxw = 0;
    logic [7:0] exp_q[$];

    always @(negedge CLK) begin
        if (FRAME_DONE === 1'b1) begin
            fd_run = fd_run + 1;
            if (fd_run == 1) fd_pulses = fd_pulses + 1;
            if (fd_run > fd_maxw) fd_maxw = fd_run;
        end else begin
            fd_run = 0;
        end
    end

    task automatic spi_xfer(input logic [7:0] addr, input logic [7:0] data, input int nbits,
                            input bit hold_ss, output logic [7:0] am, output logic [7:0] rd);
        am = 8'h00;
        rd = 8'h00;
        @(negedge CLK);
        SS = 1'b0;
        repeat (HALF) @(negedge CLK);
        for (int i = 0; i < nbits; i++) begin
            if (i < 8) MOSI = addr[7-i];
            else if (i < 16) MOSI = data[15-i];
            else MOSI = 1'b1;
            repeat (HALF) @(negedge CLK);
            if (i < 8) am[7-i] = MISO;
            else if (i < 16) rd[15-i] = MISO;
            SCLK = 1'b1;
            repeat (HALF) @(negedge CLK);
            SCLK = 1'b0;
        end
        repeat (HALF) @(negedge CLK);
        if (!hold_ss) begin
            SS = 1'b1;
            MOSI = 1'b0;
            repeat (HALF + 4) @(negedge CLK);
        end
    endtask

    task automatic test_reset();
        RST = 1'b1; SS = 1'b1; SCLK = 1'b0; MOSI = 1'b0;
        repeat (4) @(negedge CLK);
        RST = 1'b0;
        repeat (4) @(negedge CLK);
        checks++; if (MISO !== 1'b0) begin errors++; $display("FAIL reset_miso: got %b expected 0", MISO); end
        checks++; if (FRAME_DONE !== 1'b0) begin errors++; $display("FAIL reset_frame_done: got %b expected 0", FRAME_DONE); end
        checks++; if (LAST_ADDR !== 8'h00) begin errors++; $display("FAIL reset_last_addr: got %02h expected 00", LAST_ADDR); end
        checks++; if (dut.r_state !== ST_IDLE) begin errors++; $display("FAIL reset_state: got %0d expected %0d", dut.r_state, ST_IDLE); end
    endtask

    task automatic test_read_1a();
        logic [7:0] am, rd, exp;
        int p0;
        p0 = fd_pulses;
        exp_q.push_back(8'h41);
        spi_xfer(8'h1A, 8'h00, 16, 1'b0, am, rd);
        exp = exp_q.pop_front();
        checks++; if (rd !== exp) begin errors++; $display("FAIL read_1a_data: got %02h expected %02h", rd, exp); end
        checks++; if (am !== 8'h00) begin errors++; $display("FAIL read_1a_addr_miso: got %02h expected 00", am); end
        checks++; if (fd_pulses - p0 !== 1) begin errors++; $display("FAIL read_1a_done: got %0d pulses expected 1", fd_pulses - p0); end
        checks++; if (LAST_ADDR !== 8'h1A) begin errors++; $display("FAIL read_1a_last_addr: got %02h expected 1a", LAST_ADDR); end
        checks++; if (MISO !== 1'b0) begin errors++; $display("FAIL read_1a_idle_miso: got %b expected 0", MISO); end
    endtask

    task automatic test_back_to_back();
        logic [7:0] addrs [8] = '{8'h1A, 8'h1B, 8'h1C, 8'h1D, 8'h2A, 8'h2B, 8'h2C, 8'h2D};
        logic [7:0] vals  [8] = '{8'h41, 8'hDC, 8'h3B, 8'h4E, 8'h8C, 8'hB5, 8'h05, 8'hE5};
        logic [7:0] got   [8];
        logic [7:0] am, exp;
        int p0;
        p0 = fd_pulses;
        for (int i = 0; i < 8; i++) begin
            exp_q.push_back(vals[i]);
            spi_xfer(addrs[i], 8'h00, 16, 1'b0, am, got[i]);
        end
        for (int i = 0; i < 8; i++) begin
            exp = exp_q.pop_front();
            checks++; if (got[i] !== exp) begin errors++; $display("FAIL sweep_%02h: got %02h expected %02h", addrs[i], got[i], exp); end
        end
        checks++; if (fd_pulses - p0 !== 8) begin errors++; $display("FAIL sweep_done: got %0d pulses expected 8", fd_pulses - p0); end
        checks++; if (LAST_ADDR !== 8'h2D) begin errors++; $display("FAIL sweep_last_addr: got %02h expected 2d", LAST_ADDR); end
        checks++; if (fd_maxw !== 1) begin errors++; $display("FAIL done_width: got %0d cycles expected 1", fd_maxw); end
    endtask

    task automatic test_unmapped();
        logic [7:0] am, rd, exp;
        int p0;
        p0 = fd_pulses;
        exp_q.push_back(8'h00);
        spi_xfer(8'h33, 8'h00, 16, 1'b0, am, rd);
        exp = exp_q.pop_front();
        checks++; if ({am, rd} !== {8'h00, exp}) begin errors++; $display("FAIL unmapped_miso: got %02h%02h expected 00%02h", am, rd, exp); end
        checks++; if (fd_pulses - p0 !== 1) begin errors++; $display("FAIL unmapped_done: got %0d pulses expected 1", fd_pulses - p0); end
        checks++; if (LAST_ADDR !== 8'h33) begin errors++; $display("FAIL unmapped_last_addr: got %02h expected 33", LAST_ADDR); end
    endtask

    task automatic test_abort();
        logic [7:0] am, rd, exp;
        int p0;
        p0 = fd_pulses;
        spi_xfer(8'h2B, 8'h00, 5, 1'b0, am, rd);
        checks++; if (fd_pulses - p0 !== 0) begin errors++; $display("FAIL abort_done: got %0d pulses expected 0", fd_pulses - p0); end
        checks++; if (LAST_ADDR !== 8'h33) begin errors++; $display("FAIL abort_last_addr: got %02h expected 33", LAST_ADDR); end
        exp_q.push_back(8'hB5);
        spi_xfer(8'h2B, 8'h00, 16, 1'b0, am, rd);
        exp = exp_q.pop_front();
        checks++; if (rd !== exp) begin errors++; $display("FAIL abort_reread: got %02h expected %02h", rd, exp); end
        checks++; if (fd_pulses - p0 !== 1) begin errors++; $display("FAIL abort_reread_done: got %0d pulses expected 1", fd_pulses - p0); end
    endtask

    task automatic test_extra_edges();
        logic [7:0] am, rd, exp;
        int p0;
        p0 = fd_pulses;
        exp_q.push_back(8'hDC);
        spi_xfer(8'h1B, 8'h00, 20, 1'b0, am, rd);
        exp = exp_q.pop_front();
        checks++; if (rd !== exp) begin errors++; $display("FAIL extra_edges_data: got %02h expected %02h", rd, exp); end
        checks++; if (fd_pulses - p0 !== 1) begin errors++; $display("FAIL extra_edges_done: got %0d pulses expected 1", fd_pulses - p0); end
        checks++; if (LAST_ADDR !== 8'h1B) begin errors++; $display("FAIL extra_edges_last_addr: got %02h expected 1b", LAST_ADDR); end
    endtask

    task automatic test_reset_midframe();
        logic [7:0] am, rd, exp;
        int p0;
        spi_xfer(8'h1C, 8'h00, 11, 1'b1, am, rd);
        checks++; if (MISO !== 1'b1) begin errors++; $display("FAIL midframe_bit4: got %b expected 1", MISO); end
        RST = 1'b1;
        #1;
        checks++; if (MISO !== 1'b0) begin errors++; $display("FAIL midframe_rst_miso: got %b expected 0", MISO); end
        checks++; if (dut.r_state !== ST_IDLE) begin errors++; $display("FAIL midframe_rst_state: got %0d expected %0d", dut.r_state, ST_IDLE); end
        checks++; if (LAST_ADDR !== 8'h00) begin errors++; $display("FAIL midframe_rst_last_addr: got %02h expected 00", LAST_ADDR); end
        SS = 1'b1; SCLK = 1'b0; MOSI = 1'b0;
        repeat (4) @(negedge CLK);
        RST = 1'b0;
        repeat (4) @(negedge CLK);
        p0 = fd_pulses;
        exp_q.push_back(8'h3B);
        spi_xfer(8'h1C, 8'h00, 16, 1'b0, am, rd);
        exp = exp_q.pop_front();
        checks++; if (rd !== exp) begin errors++; $display("FAIL midframe_reread: got %02h expected %02h", rd, exp); end
        checks++; if (fd_pulses - p0 !== 1) begin errors++; $display("FAIL midframe_reread_done: got %0d pulses expected 1", fd_pulses - p0); end
    endtask

    task automatic test_write();
        logic [7:0] am, rd, exp;
        int p0;
        p0 = fd_pulses;
        spi_xfer(8'h9D, 8'hA5, 16, 1'b0, am, rd);
        checks++; if ({am, rd} !== 16'h0000) begin errors++; $display("FAIL write_miso: got %02h%02h expected 0000", am, rd); end
        checks++; if (fd_pulses - p0 !== 1) begin errors++; $display("FAIL write_done: got %0d pulses expected 1", fd_pulses - p0); end
        checks++; if (LAST_ADDR !== 8'h9D) begin errors++; $display("FAIL write_last_addr: got %02h expected 9d", LAST_ADDR); end
`ifdef SPI_RESPONDER_WRITE_EN
        exp_q.push_back(8'hA5);
`else
        exp_q.push_back(8'h4E);
`endif
        spi_xfer(8'h1D, 8'h00, 16, 1'b0, am, rd);
        exp = exp_q.pop_front();
        checks++; if (rd !== exp) begin errors++; $display("FAIL write_readback: got %02h expected %02h", rd, exp); end
    endtask

    initial begin
        test_reset();
        test_read_1a();
        test_back_to_back();
        test_unmapped();
        test_abort();
        test_extra_edges();
        test_reset_midframe();
        test_write();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/spi_responder_regs.md
SPI_RESPONDER_REGS -- requirements
Module: spi_responder_regs

Interface
- REQ-001: SHALL have parameter SYNC_STAGES, default 2; synchronizer depth for SCLK, MOSI and SS, legal range 2..3.
- REQ-002: SHALL have parameter NUM_REGS, default 8; number of register-bank entries.
- REQ-003: SHALL have port CLK, input, 1 bit; the block's single system clock, with all logic on its rising edge.
- REQ-004: SHALL have port RST, input, 1 bit; asynchronous, active-high reset.
- REQ-005: SHALL have port SCLK, input, 1 bit; SPI serial clock, asynchronous to CLK, mode 0.
- REQ-006: SHALL have port MOSI, input, 1 bit; serial data from the initiator, MSB first.
- REQ-007: SHALL have port SS, input, 1 bit; responder select, active-low.
- REQ-008: SHALL have port MISO, output, 1 bit; serial data to the initiator, held 0 whenever not driving data, so that it is wired-OR safe.
- REQ-009: SHALL have port FRAME_DONE, output, 1 bit; one-CLK pulse on completion of a full 16-bit frame.
- REQ-010: SHALL have port LAST_ADDR, output, 8 bits; address byte of the last completed frame.

Function
- REQ-011: Frame SHALL be 8 address bits then 8 data bits, MSB first.
- REQ-012: MOSI SHALL be sampled on synchronized SCLK rising edges.
- REQ-013: MISO SHALL change only on synchronized SCLK falling edges.
- REQ-014: Address bit 7 SHALL be the write flag (1 = write, 0 = read).
- REQ-015: State machine SHALL have states IDLE, ADDR, DATA, DONE. Transitions:
  - IDLE->ADDR when synchronized SS falls.
  - ADDR->DATA after the 8th rising edge.
  - DATA->DONE after the 16th rising edge.
  - DONE->IDLE on the next CLK.
- REQ-016: Synchronized SS high in any state SHALL force IDLE next CLK, zero the bit counter, drive MISO 0, and produce no FRAME_DONE, LAST_ADDR update or write.
- REQ-017: Read lookup SHALL occur on the CLK after the 8th rising edge.
- REQ-018: Read data bit 7 SHALL appear on MISO at the following falling edge; each later falling edge shifts out the next bit.
- REQ-019: Mapped addresses SHALL be 0x1A, 0x1B, 0x1C, 0x1D, 0x2A, 0x2B, 0x2C, 0x2D, entries 0..7 in that order, matched on address bits 6:0.
- REQ-020: Reads of unmapped addresses SHALL return 0x00.
- REQ-021: MISO SHALL be 0 in IDLE, in ADDR and during write frames.
- REQ-022: Input-to-response latency SHALL be at most SYNC_STAGES+1 CLK; SCLK high and low times SHALL each be at least SYNC_STAGES+2 CLK periods (integration requirement).
- REQ-023: FRAME_DONE SHALL pulse for 1 CLK in DONE, and LAST_ADDR SHALL load the address byte in the same cycle.
- REQ-024: Extra SCLK edges after the 16th bit while SS is still low SHALL be ignored until SS rises.

Reset
- REQ-025: RST SHALL act immediately, including mid-frame, and force:
  - state IDLE and bit counter 0;
  - MISO 0, FRAME_DONE 0, LAST_ADDR 0x00;
  - synchronizers to SCLK=0, MOSI=0, SS=1;
  - register bank to 0x41, 0xDC, 0x3B, 0x4E, 0x8C, 0xB5, 0x05, 0xE5 for entries 0..7.

Configuration
- REQ-026: With macro SPI_RESPONDER_WRITE_EN defined, a write frame to a mapped address SHALL update that entry in DONE.
- REQ-027: With SPI_RESPONDER_WRITE_EN defined, a write frame to an unmapped address SHALL be discarded.
- REQ-028: Without SPI_RESPONDER_WRITE_EN, the bank SHALL be constant reset values and write frames SHALL complete with FRAME_DONE but change nothing.

Structure
- REQ-029: Shared package spi_pkg SHALL hold:
  - the state enum;
  - the address and reset-value constants;
  - frame-length constants (8 and 16).
- REQ-030: Sub-module spi_sync SHALL implement one SYNC_STAGES-deep synchronizer with rise/fall pulse outputs; it is instantiated for SCLK and SS, and MOSI uses the synchronizer only.

Verification
- REQ-031: Read 0x1A: drive SS low, address 0x1A, 8 dummy clocks -> MISO serial 0x41, FRAME_DONE one pulse, LAST_ADDR 0x1A.
- REQ-032: Sweep all 8 mapped addresses back-to-back -> reads 0x41, 0xDC, 0x3B, 0x4E, 0x8C, 0xB5, 0x05, 0xE5.
- REQ-033: Read 0x33 -> MISO 0x00 throughout the frame, FRAME_DONE pulses.
- REQ-034: Raise SS after 5 address bits, then a full frame for 0x2B -> first frame gives no FRAME_DONE, second returns 0xB5.
- REQ-035: Assert RST at data bit 3 of a 0x1C read -> MISO 0 and state IDLE immediately; the next 0x1C read returns 0x3B.
- REQ-036: With SPI_RESPONDER_WRITE_EN: write 0x9D/0xA5 then read 0x1D -> 0xA5. Without it: the same sequence reads back 0x4E.
